// File: rtl/lenet_result_checker.sv
// On-chip self-check for the LeNet accelerator: times compute_start..compute_finish, then
// compares the activation SRAM against a golden SRAM and reports per-layer error counts.
module lenet_result_checker #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int NUM_SEG        = 6,
    parameter int CNT_W          = 32,
    parameter int ERR_W          = 10,
    parameter int TIMEOUT_CYCLES = 26000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      compute_start,
    input  logic                      compute_finish,
    input  logic [NUM_SEG*ADDR_W-1:0] seg_end,
    output logic                      act_rd_en,
    output logic [ADDR_W-1:0]         act_rd_addr,
    input  logic [DATA_W-1:0]         act_rd_data,
    output logic [ADDR_W-1:0]         gold_rd_addr,
    input  logic [DATA_W-1:0]         gold_rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timed_out,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [NUM_SEG*ERR_W-1:0]  err_seg,
    output logic [ERR_W-1:0]          err_total,
    output logic                      first_err_valid,
    output logic [ADDR_W-1:0]         first_err_addr
);
    localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {IDLE, RUN, SCAN, DONE, TIMEOUT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] issue_ptr;
    logic [SEG_W-1:0]  issue_seg;
    logic [SEG_W-1:0]  req_seg;
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic [SEG_W-1:0]  cmp_seg;
    logic [ERR_W-1:0]  err_cnt [NUM_SEG];
    logic [ADDR_W-1:0] scan_end;
    logic [CNT_W-1:0]  cnt_next;
    logic              issue;
    logic              mismatch;

    assign scan_end     = seg_end[(NUM_SEG-1)*ADDR_W +: ADDR_W];
    assign cnt_next     = cycle_count + 1'b1;
    assign gold_rd_addr = act_rd_addr;
    assign mismatch     = cmp_vld && (act_rd_data !== gold_rd_data);
    // The first read goes out on the same edge that accepts compute_finish.
    assign issue        = ((state == SCAN) || (state == RUN && compute_finish))
                          && (issue_ptr != scan_end);

    // Ends are non-decreasing, so the segment is the number of ends already passed;
    // empty segments are skipped naturally.
    always_comb begin
        issue_seg = '0;
        for (int i = 0; i < NUM_SEG - 1; i++) begin
            if (seg_end[i*ADDR_W +: ADDR_W] <= issue_ptr) issue_seg = SEG_W'(i + 1);
        end
    end

    for (genvar g = 0; g < NUM_SEG; g++) begin : g_err
        assign err_seg[g*ERR_W +: ERR_W] = err_cnt[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            issue_ptr       <= '0;
            req_seg         <= '0;
            cmp_vld         <= 1'b0;
            cmp_addr        <= '0;
            cmp_seg         <= '0;
            act_rd_en       <= 1'b0;
            act_rd_addr     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timed_out       <= 1'b0;
            cycle_count     <= '0;
            err_total       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            for (int i = 0; i < NUM_SEG; i++) err_cnt[i] <= '0;
        end else begin
            // Request stage: address and segment travel together into the compare stage.
            if (issue) begin
                act_rd_en   <= 1'b1;
                act_rd_addr <= issue_ptr;
                req_seg     <= issue_seg;
                issue_ptr   <= issue_ptr + 1'b1;
            end else begin
                act_rd_en   <= 1'b0;
            end
            cmp_vld  <= act_rd_en;
            cmp_addr <= act_rd_addr;
            cmp_seg  <= req_seg;

            if (mismatch) begin
                if (err_cnt[cmp_seg] != ERR_MAX) err_cnt[cmp_seg] <= err_cnt[cmp_seg] + 1'b1;
                if (err_total != ERR_MAX) err_total <= err_total + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_addr;
                end
            end

            case (state)
                IDLE, DONE, TIMEOUT: begin
                    if (compute_start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        timed_out       <= 1'b0;
                        cycle_count     <= '0;
                        issue_ptr       <= '0;
                        err_total       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                        for (int i = 0; i < NUM_SEG; i++) err_cnt[i] <= '0;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    if (compute_finish) begin
                        state <= SCAN;
                    end else if (cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
                        state     <= TIMEOUT;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                    end
                end
                SCAN: begin
                    // Finished once every address is issued and the last compare has landed.
                    if (issue_ptr == scan_end && !act_rd_en && !cmp_vld) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_total == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lenet_result_checker.sv
// Scoreboard bench: two checker instances (default limits, and a short timeout with 4-bit counters).
module tb_lenet_result_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, compute_start, compute_finish;
    logic [95:0] seg_end;

    logic        act_rd_en_a, busy_a, done_a, pass_a, timed_out_a, first_err_valid_a;
    logic [15:0] act_rd_addr_a, gold_rd_addr_a, first_err_addr_a;
    logic [31:0] act_rd_data_a, gold_rd_data_a, cycle_count_a;
    logic [59:0] err_seg_a;
    logic [9:0]  err_total_a;

    logic        act_rd_en_b, busy_b, done_b, pass_b, timed_out_b, first_err_valid_b;
    logic [15:0] act_rd_addr_b, gold_rd_addr_b, first_err_addr_b;
    logic [31:0] act_rd_data_b, gold_rd_data_b, cycle_count_b;
    logic [23:0] err_seg_b;
    logic [3:0]  err_total_b;

    lenet_result_checker #(.TIMEOUT_CYCLES(26000), .ERR_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .compute_start(compute_start), .compute_finish(compute_finish),
        .seg_end(seg_end), .act_rd_en(act_rd_en_a), .act_rd_addr(act_rd_addr_a),
        .act_rd_data(act_rd_data_a), .gold_rd_addr(gold_rd_addr_a), .gold_rd_data(gold_rd_data_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timed_out(timed_out_a),
        .cycle_count(cycle_count_a), .err_seg(err_seg_a), .err_total(err_total_a),
        .first_err_valid(first_err_valid_a), .first_err_addr(first_err_addr_a));

    lenet_result_checker #(.TIMEOUT_CYCLES(50), .ERR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .compute_start(compute_start), .compute_finish(compute_finish),
        .seg_end(seg_end), .act_rd_en(act_rd_en_b), .act_rd_addr(act_rd_addr_b),
        .act_rd_data(act_rd_data_b), .gold_rd_addr(gold_rd_addr_b), .gold_rd_data(gold_rd_data_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timed_out(timed_out_b),
        .cycle_count(cycle_count_b), .err_seg(err_seg_b), .err_total(err_total_b),
        .first_err_valid(first_err_valid_b), .first_err_addr(first_err_addr_b));

    logic [31:0] act_mem  [1024];
    logic [31:0] gold_mem [1024];

    always @(posedge clk) begin
        act_rd_data_a  <= act_mem[act_rd_addr_a[9:0]];
        gold_rd_data_a <= gold_mem[gold_rd_addr_a[9:0]];
        act_rd_data_b  <= act_mem[act_rd_addr_b[9:0]];
        gold_rd_data_b <= gold_mem[gold_rd_addr_b[9:0]];
    end

    typedef struct packed {
        logic [31:0]      cyc;
        logic             pass;
        logic             to;
        logic [15:0]      total;
        logic             fv;
        logic [15:0]      faddr;
        logic [5:0][15:0] seg;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   checks = 0;
    int   errors = 0;
    int   ends[6];
    int   rd_a = 0, rd_b = 0;
    logic done_a_q = 1'b0, done_b_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: walk the image address by address.
    function automatic exp_t model(input int errw, input int cyc, input bit to);
        exp_t e;
        int   sat;
        int   s;
        sat   = (1 << errw) - 1;
        e     = '0;
        e.cyc = 32'(cyc);
        e.to  = to;
        if (!to) begin
            for (int a = 0; a < ends[5]; a++) begin
                s = 0;
                while (s < 5 && a >= ends[s]) s++;
                if (act_mem[a] !== gold_mem[a]) begin
                    if (int'(e.seg[s]) < sat) e.seg[s] = e.seg[s] + 16'd1;
                    if (int'(e.total) < sat) e.total = e.total + 16'd1;
                    if (!e.fv) begin
                        e.fv    = 1'b1;
                        e.faddr = 16'(a);
                    end
                end
            end
            e.pass = (e.total == 16'd0);
        end
        return e;
    endfunction

    task automatic compare(input string t, input exp_t e, input logic [31:0] cyc, input logic ps,
                           input logic to, input logic [15:0] tot, input logic fv,
                           input logic [15:0] fa, input logic [5:0][15:0] sg);
        check({t, "_cycles"}, cyc, e.cyc);
        check({t, "_pass"}, ps, e.pass);
        check({t, "_timed_out"}, to, e.to);
        check({t, "_total"}, tot, e.total);
        check({t, "_first_vld"}, fv, e.fv);
        check({t, "_first_addr"}, fa, e.faddr);
        for (int i = 0; i < 6; i++) check($sformatf("%s_seg%0d", t, i), sg[i], e.seg[i]);
    endtask

    function automatic logic [5:0][15:0] wide_a(input logic [59:0] v);
        logic [5:0][15:0] r;
        for (int i = 0; i < 6; i++) r[i] = 16'(v[i*10 +: 10]);
        return r;
    endfunction

    function automatic logic [5:0][15:0] wide_b(input logic [23:0] v);
        logic [5:0][15:0] r;
        for (int i = 0; i < 6; i++) r[i] = 16'(v[i*4 +: 4]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (act_rd_en_a) rd_a++;
        if (act_rd_en_b) rd_b++;
        check("busy_and_done_a", busy_a & done_a, 0);
        check("busy_and_done_b", busy_b & done_b, 0);
        if (done_a && !done_a_q) begin
            check("sb_a_pending", sb_a.size() > 0, 1);
            if (sb_a.size() > 0)
                compare("res_a", sb_a.pop_front(), cycle_count_a, pass_a, timed_out_a,
                        16'(err_total_a), first_err_valid_a, first_err_addr_a, wide_a(err_seg_a));
        end
        if (done_b && !done_b_q) begin
            check("sb_b_pending", sb_b.size() > 0, 1);
            if (sb_b.size() > 0)
                compare("res_b", sb_b.pop_front(), cycle_count_b, pass_b, timed_out_b,
                        16'(err_total_b), first_err_valid_b, first_err_addr_b, wide_b(err_seg_b));
        end
        done_a_q = done_a;
        done_b_q = done_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        compute_start = 1'b1;
        tick();
        compute_start = 1'b0;
    endtask

    task automatic finish_after(input int n);
        repeat (n - 1) tick();
        compute_finish = 1'b1;
        tick();
        compute_finish = 1'b0;
    endtask

    task automatic wait_done(input string t, input bit on_b, input int exp_lat);
        int k = 0;
        while (!(on_b ? done_b : done_a) && k < 3000) begin
            tick();
            k++;
        end
        check({t, "_latency"}, k, exp_lat);
    endtask

    task automatic set_ends(input int e0, input int e1, input int e2,
                            input int e3, input int e4, input int e5);
        ends = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < 6; i++) seg_end[i*16 +: 16] = 16'(ends[i]);
    endtask

    task automatic restore_mem();
        for (int i = 0; i < 1024; i++) act_mem[i] = gold_mem[i];
    endtask

    task automatic corrupt(input int a);
        act_mem[a] = gold_mem[a] ^ (32'h1 << (a % 32));
    endtask

    task automatic check_zero_a(input string t);
        check({t, "_busy"}, busy_a, 0);
        check({t, "_done"}, done_a, 0);
        check({t, "_pass"}, pass_a, 0);
        check({t, "_timed_out"}, timed_out_a, 0);
        check({t, "_cycles"}, cycle_count_a, 0);
        check({t, "_err_seg"}, err_seg_a, 0);
        check({t, "_err_total"}, err_total_a, 0);
        check({t, "_first_vld"}, first_err_valid_a, 0);
        check({t, "_first_addr"}, first_err_addr_a, 0);
        check({t, "_rd_en"}, act_rd_en_a, 0);
        check({t, "_rd_addr"}, act_rd_addr_a, 0);
        check({t, "_gold_addr"}, gold_rd_addr_a, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int found;
        rst_n = 1'b0;
        compute_start = 1'b0;
        compute_finish = 1'b0;
        for (int i = 0; i < 1024; i++) gold_mem[i] = $urandom;
        restore_mem();
        set_ends(256, 592, 692, 722, 743, 753);
        repeat (3) tick();
        check_zero_a("reset");
        check("reset_b_done", done_b, 0);
        check("reset_b_busy", busy_b, 0);
        rst_n = 1'b1;
        tick();

        // Clean run on A; B times out at 50 and must never read.
        start_pulse();
        sb_a.push_back(model(10, 100, 1'b0));
        sb_b.push_back(model(4, 50, 1'b1));
        r0 = rd_b;
        wait_done("timeout_b", 1'b1, 50);
        check("timeout_flag", timed_out_b, 1);
        check("timeout_cycles", cycle_count_b, 50);
        r0 = rd_b - r0;
        check("timeout_no_reads", r0, 0);
        r0 = rd_a;
        finish_after(50);
        wait_done("clean_a", 1'b0, 755);
        tick();
        check("clean_pass", pass_a, 1);
        check("clean_reads", rd_a - r0, 753);

        // Finish coincides with B's limit: finish wins.
        start_pulse();
        sb_a.push_back(model(10, 50, 1'b0));
        sb_b.push_back(model(4, 50, 1'b0));
        finish_after(50);
        check("f50_b_busy", busy_b, 1);
        check("f50_b_timed_out", timed_out_b, 0);
        wait_done("f50_a", 1'b0, 755);
        tick();

        // Layer boundary errors.
        corrupt(255); corrupt(256); corrupt(591); corrupt(752);
        start_pulse();
        sb_a.push_back(model(10, 20, 1'b0));
        sb_b.push_back(model(4, 20, 1'b0));
        finish_after(20);
        wait_done("bnd_a", 1'b0, 755);
        tick();
        check("bnd_seg0", err_seg_a[9:0], 1);
        check("bnd_seg1", err_seg_a[19:10], 2);
        check("bnd_seg5", err_seg_a[59:50], 1);
        check("bnd_total", err_total_a, 4);
        check("bnd_first", first_err_addr_a, 255);

        // A start in DONE clears previous results.
        restore_mem();
        start_pulse();
        check("restart_total", err_total_a, 0);
        check("restart_first_vld", first_err_valid_a, 0);
        check("restart_busy", busy_a, 1);
        check("restart_done", done_a, 0);
        sb_a.push_back(model(10, 30, 1'b0));
        sb_b.push_back(model(4, 30, 1'b0));
        finish_after(30);
        wait_done("restart_a", 1'b0, 755);
        tick();

        // Saturation of the 4-bit counters.
        for (int i = 0; i < 256; i++) corrupt(i);
        start_pulse();
        sb_a.push_back(model(10, 10, 1'b0));
        sb_b.push_back(model(4, 10, 1'b0));
        finish_after(10);
        wait_done("sat_a", 1'b0, 755);
        tick();
        check("sat_seg0", err_seg_b[3:0], 15);
        check("sat_total", err_total_b, 15);
        check("sat_first", first_err_addr_b, 0);
        restore_mem();

        // Empty segments.
        set_ends(4, 4, 4, 8, 8, 8);
        corrupt(5);
        start_pulse();
        sb_a.push_back(model(10, 5, 1'b0));
        sb_b.push_back(model(4, 5, 1'b0));
        finish_after(5);
        wait_done("empty_a", 1'b0, 10);
        tick();
        check("empty_seg3", err_seg_a[39:30], 1);
        restore_mem();

        // Zero-length image.
        set_ends(0, 0, 0, 0, 0, 0);
        r0 = rd_a;
        start_pulse();
        sb_a.push_back(model(10, 5, 1'b0));
        sb_b.push_back(model(4, 5, 1'b0));
        finish_after(5);
        wait_done("zero_a", 1'b0, 1);
        tick();
        check("zero_pass", pass_a, 1);
        check("zero_reads", rd_a - r0, 0);

        // Reset in the middle of a scan, then restart from address 0.
        set_ends(256, 592, 692, 722, 743, 753);
        start_pulse();
        finish_after(10);
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            if (act_rd_en_a && act_rd_addr_a == 16'd300) found = 1;
            else tick();
        end
        check("midscan_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check_zero_a("midscan_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("after_rst_busy", busy_a, 0);
        start_pulse();
        sb_a.push_back(model(10, 40, 1'b0));
        sb_b.push_back(model(4, 40, 1'b0));
        finish_after(40);
        check("rescan_en", act_rd_en_a, 1);
        check("rescan_addr0", act_rd_addr_a, 0);
        wait_done("rescan_a", 1'b0, 755);
        tick();

        check("sb_a_left", sb_a.size(), 0);
        check("sb_b_left", sb_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
